// File: rtl/thermal_pkg.sv
// Shared types and constants for the thermal plant emulator.
package thermal_pkg;

    localparam int unsigned TEMP_W  = 8;
    localparam int unsigned TEMP_SW = TEMP_W + 1;
    localparam int unsigned DIV_W   = 16;

    localparam logic [TEMP_W-1:0] LFSR_SEED = 8'hA5;

    typedef enum logic [1:0] {
        P_IDLE  = 2'd0,
        P_HEAT  = 2'd1,
        P_COOL  = 2'd2,
        P_FAULT = 2'd3
    } plant_state_t;

    // Saturate a signed 9-bit intermediate into the [lo, hi] temperature window.
    function automatic logic [TEMP_W-1:0] clamp_temp(
        input logic signed [TEMP_SW-1:0] v,
        input logic [TEMP_W-1:0]         lo,
        input logic [TEMP_W-1:0]         hi
    );
        logic [TEMP_W-1:0] r;
        if (v < $signed({1'b0, lo})) begin
            r = lo;
        end else if (v > $signed({1'b0, hi})) begin
            r = hi;
        end else begin
            r = v[TEMP_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/plant_prescaler.sv
// Mod-N step prescaler with synchronous clear; N is a runtime input.
module plant_prescaler
    import thermal_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count_q;
    logic             wrap_c;

    assign wrap_c = (count_q == div - DIV_W'(1));
    // A clear discards any progress, including a wrap landing on the same edge.
    assign tick   = !clear && wrap_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear || wrap_c) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/thermal_plant_model.sv
// Thermal plant emulator: integrates heater/cooler commands into current_temp.
// Optional step noise is enabled with the PLANT_NOISE_EN macro.
module thermal_plant_model
    import thermal_pkg::*;
#(
    parameter logic [TEMP_W-1:0] INIT_TEMP    = 8'd25,
    parameter logic [TEMP_W-1:0] AMBIENT_TEMP = 8'd25,
    parameter int unsigned       HEAT_DIV     = 4,
    parameter int unsigned       COOL_DIV     = 4,
    parameter int unsigned       DRIFT_DIV    = 16,
    parameter logic [TEMP_W-1:0] TEMP_MIN     = 8'd0,
    parameter logic [TEMP_W-1:0] TEMP_MAX     = 8'd120
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              heater_on,
    input  logic              cooler_on,
    input  logic              load,
    input  logic [TEMP_W-1:0] load_temp,
    output logic [TEMP_W-1:0] current_temp,
    output logic              temp_step,
    output logic              at_limit,
    output logic              fault
);

    localparam logic INIT_AT_LIMIT = (INIT_TEMP == TEMP_MIN) || (INIT_TEMP == TEMP_MAX);

    plant_state_t      state_q, state_next;
    logic [TEMP_W-1:0] temp_q, temp_next;
    logic              step_q, step_next;
    logic              lim_q, lim_next;
    logic              fault_q, fault_next;

    logic              presc_clear;
    logic [DIV_W-1:0]  presc_div;
    logic              presc_tick;
    logic              step_apply;

    logic signed [TEMP_SW-1:0] temp_s;
    logic signed [TEMP_SW-1:0] step_raw;
    logic [TEMP_W-1:0]         step_val;

    plant_prescaler u_prescaler (
        .clk   (clk),
        .rst_n (reset),
        .clear (presc_clear),
        .div   (presc_div),
        .tick  (presc_tick)
    );

`ifdef PLANT_NOISE_EN
    logic [TEMP_W-1:0] lfsr_q, lfsr_next;

    // Fibonacci LFSR, taps 8,6,5,4; a set LSB suppresses the current step.
    always_comb begin
        lfsr_next = lfsr_q;
        if (load) begin
            lfsr_next = LFSR_SEED;
        end else if (presc_tick) begin
            lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next;
        end
    end

    assign step_apply = !lfsr_q[0];
`else
    assign step_apply = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= P_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next state, prescaler control and datapath next values.
    always_comb begin
        state_next  = state_q;
        presc_div   = DIV_W'(DRIFT_DIV);
        presc_clear = 1'b0;
        temp_s      = $signed({1'b0, temp_q});
        step_raw    = temp_s;
        step_val    = temp_q;
        temp_next   = temp_q;
        step_next   = 1'b0;

        if (load) begin
            state_next = P_IDLE;
        end else if (state_q == P_FAULT) begin
            state_next = P_FAULT;
        end else if (heater_on && cooler_on) begin
            state_next = P_FAULT;
        end else if (heater_on) begin
            state_next = P_HEAT;
        end else if (cooler_on) begin
            state_next = P_COOL;
        end else begin
            state_next = P_IDLE;
        end

        case (state_q)
            P_HEAT:  presc_div = DIV_W'(HEAT_DIV);
            P_COOL:  presc_div = DIV_W'(COOL_DIV);
            default: presc_div = DIV_W'(DRIFT_DIV);
        endcase

        // Fault holds the prescaler at zero; any state change restarts the period.
        presc_clear = load || (state_next != state_q) || (state_q == P_FAULT);

        case (state_q)
            P_HEAT: step_raw = temp_s + $signed(TEMP_SW'(1));
            P_COOL: step_raw = temp_s - $signed(TEMP_SW'(1));
            P_IDLE: begin
                if (temp_q < AMBIENT_TEMP) begin
                    step_raw = temp_s + $signed(TEMP_SW'(1));
                end else if (temp_q > AMBIENT_TEMP) begin
                    step_raw = temp_s - $signed(TEMP_SW'(1));
                end else begin
                    step_raw = temp_s;
                end
            end
            default: step_raw = temp_s;
        endcase
        step_val = clamp_temp(step_raw, TEMP_MIN, TEMP_MAX);

        if (load) begin
            temp_next = clamp_temp($signed({1'b0, load_temp}), TEMP_MIN, TEMP_MAX);
        end else if (presc_tick && step_apply) begin
            temp_next = step_val;
            step_next = (step_val != temp_q);
        end

        fault_next = (state_next == P_FAULT);
        lim_next   = (temp_next == TEMP_MIN) || (temp_next == TEMP_MAX);
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            temp_q  <= INIT_TEMP;
            step_q  <= 1'b0;
            lim_q   <= INIT_AT_LIMIT;
            fault_q <= 1'b0;
        end else begin
            temp_q  <= temp_next;
            step_q  <= step_next;
            lim_q   <= lim_next;
            fault_q <= fault_next;
        end
    end

    assign current_temp = temp_q;
    assign temp_step    = step_q;
    assign at_limit     = lim_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_thermal_plant_model.sv
// Directed bench for thermal_plant_model: vector table plus async-reset sequences.
module tb_thermal_plant_model;

    logic       clk;
    logic       reset;
    logic       heater_on;
    logic       cooler_on;
    logic       load;
    logic [7:0] load_temp;
    logic [7:0] current_temp;
    logic       temp_step;
    logic       at_limit;
    logic       fault;

    int n_total;
    int n_pass;

    thermal_plant_model dut (
        .clk          (clk),
        .reset        (reset),
        .heater_on    (heater_on),
        .cooler_on    (cooler_on),
        .load         (load),
        .load_temp    (load_temp),
        .current_temp (current_temp),
        .temp_step    (temp_step),
        .at_limit     (at_limit),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [7:0] lt;
        logic       h;
        logic       c;
        int         n;
        int         temp;
        int         steps;
        int         lim;
        int         flt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ld, input int lt, input logic h, input logic c,
                                input int n, input int temp, input int steps,
                                input int lim, input int flt);
        vec_t v;
        v.ld = ld; v.lt = 8'(lt); v.h = h; v.c = c; v.n = n;
        v.temp = temp; v.steps = steps; v.lim = lim; v.flt = flt;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one record for v.n edges (load only on the first), counting step pulses.
    task automatic apply(input vec_t v, output int steps);
        steps     = 0;
        load      = v.ld;
        load_temp = v.lt;
        heater_on = v.h;
        cooler_on = v.c;
        for (int i = 0; i < v.n; i++) begin
            @(posedge clk);
            #1;
            if (temp_step) steps++;
            load = 1'b0;
        end
    endtask

    initial begin
        int steps;
        n_total   = 0;
        n_pass    = 0;
        reset     = 1'b0;
        heater_on = 1'b0;
        cooler_on = 1'b0;
        load      = 1'b0;
        load_temp = 8'd0;

        //               ld lt   h     c     n   temp st lim flt
        vecs.push_back(mk(0, 0,   1'b1, 1'b0, 41, 35, 10, 0, 0));
        vecs.push_back(mk(1, 118, 1'b0, 1'b0, 1,  118, 0, 0, 0));
        vecs.push_back(mk(0, 0,   1'b1, 1'b0, 5,  119, 1, 0, 0));
        vecs.push_back(mk(0, 0,   1'b1, 1'b0, 4,  120, 1, 1, 0));
        vecs.push_back(mk(0, 0,   1'b1, 1'b0, 12, 120, 0, 1, 0));
        vecs.push_back(mk(1, 30,  1'b0, 1'b0, 1,  30,  0, 0, 0));
        vecs.push_back(mk(0, 0,   1'b0, 1'b0, 80, 25,  5, 0, 0));
        vecs.push_back(mk(0, 0,   1'b0, 1'b0, 32, 25,  0, 0, 0));
        vecs.push_back(mk(1, 25,  1'b0, 1'b0, 1,  25,  0, 0, 0));
        vecs.push_back(mk(0, 0,   1'b1, 1'b0, 12, 27,  2, 0, 0));
        vecs.push_back(mk(0, 0,   1'b1, 1'b1, 1,  27,  0, 0, 1));
        vecs.push_back(mk(0, 0,   1'b1, 1'b1, 8,  27,  0, 0, 1));
        vecs.push_back(mk(0, 0,   1'b0, 1'b0, 20, 27,  0, 0, 1));
        vecs.push_back(mk(0, 0,   1'b1, 1'b0, 8,  27,  0, 0, 1));
        vecs.push_back(mk(1, 50,  1'b0, 1'b0, 1,  50,  0, 0, 0));
        vecs.push_back(mk(1, 3,   1'b0, 1'b0, 1,  3,   0, 0, 0));
        vecs.push_back(mk(0, 0,   1'b0, 1'b1, 5,  2,   1, 0, 0));
        vecs.push_back(mk(0, 0,   1'b0, 1'b1, 4,  1,   1, 0, 0));
        vecs.push_back(mk(0, 0,   1'b0, 1'b1, 4,  0,   1, 1, 0));
        vecs.push_back(mk(0, 0,   1'b0, 1'b1, 12, 0,   0, 1, 0));
        vecs.push_back(mk(1, 200, 1'b1, 1'b0, 1,  120, 0, 1, 0));
        vecs.push_back(mk(1, 60,  1'b0, 1'b0, 1,  60,  0, 0, 0));
        vecs.push_back(mk(0, 0,   1'b1, 1'b0, 3,  60,  0, 0, 0));
        vecs.push_back(mk(0, 0,   1'b0, 1'b1, 3,  60,  0, 0, 0));
        vecs.push_back(mk(0, 0,   1'b0, 1'b1, 2,  59,  1, 0, 0));
        vecs.push_back(mk(0, 0,   1'b0, 1'b0, 17, 58,  1, 0, 0));
        vecs.push_back(mk(1, 40,  1'b1, 1'b1, 1,  40,  0, 0, 0));
        vecs.push_back(mk(0, 0,   1'b1, 1'b1, 1,  40,  0, 0, 1));
        vecs.push_back(mk(1, 25,  1'b0, 1'b0, 1,  25,  0, 0, 0));

        #12;
        check("reset temp",  int'(current_temp), 25);
        check("reset step",  int'(temp_step), 0);
        check("reset limit", int'(at_limit), 0);
        check("reset fault", int'(fault), 0);

        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i], steps);
            check($sformatf("v%0d temp", i),  int'(current_temp), vecs[i].temp);
            check($sformatf("v%0d steps", i), steps, vecs[i].steps);
            check($sformatf("v%0d limit", i), int'(at_limit), vecs[i].lim);
            check($sformatf("v%0d fault", i), int'(fault), vecs[i].flt);
        end

        // Async reset between edges right after a step pulse.
        apply(mk(0, 0, 1'b1, 1'b0, 9, 0, 0, 0, 0), steps);
        check("pre-reset temp",  int'(current_temp), 27);
        check("pre-reset pulse", int'(temp_step), 1);
        #1;
        reset = 1'b0;
        #1;
        check("async reset temp", int'(current_temp), 25);
        check("async reset step", int'(temp_step), 0);
        check("async reset limit", int'(at_limit), 0);
        heater_on = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Async reset also clears a latched fault.
        apply(mk(0, 0, 1'b1, 1'b1, 2, 0, 0, 0, 0), steps);
        check("fault latched", int'(fault), 1);
        #1;
        reset = 1'b0;
        #1;
        check("async reset fault", int'(fault), 0);
        heater_on = 1'b0;
        cooler_on = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post-release fault", int'(fault), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/thermal_plant_model.md
# thermal_plant_model

Synthesizable thermal plant emulator that closes the loop around the temperature controller. It consumes the controller's `heater_on`/`cooler_on` commands and produces the `current_temp` value the controller regulates against. Temperature rises while heating, falls while cooling, and drifts toward ambient otherwise. Used in closed-loop benches and on FPGA demo builds in place of a real sensor.

## Interface
- `INIT_TEMP`, 8'd25, `current_temp` value after reset
- `AMBIENT_TEMP`, 8'd25, idle drift target
- `HEAT_DIV`, 4, clock cycles per +1 step while heating (≥1)
- `COOL_DIV`, 4, clock cycles per −1 step while cooling (≥1)
- `DRIFT_DIV`, 16, clock cycles per 1-unit step toward ambient when idle (≥1)
- `TEMP_MIN`, 8'd0, lower clamp
- `TEMP_MAX`, 8'd120, upper clamp
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `heater_on`  in  1  heat command from controller
- `cooler_on`  in  1  cool command from controller
- `load`  in  1  synchronous preset strobe
- `load_temp`  in  8  preset value, unsigned
- `current_temp`  out  8  modelled temperature, unsigned, registered
- `temp_step`  out  1  one-cycle pulse on each model-driven change of `current_temp`
- `at_limit`  out  1  `current_temp` == `TEMP_MIN` or `TEMP_MAX`
- `fault`  out  1  sticky: heater and cooler commanded together

## Operation
- Reset values: state P_IDLE, `current_temp`=`INIT_TEMP`, prescaler=0, `temp_step`=0, `fault`=0; `at_limit` is decoded from `current_temp`.
- States are P_IDLE, P_HEAT, P_COOL and P_FAULT. At each edge the next state is decoded from the inputs: both commands high → P_FAULT; heater only → P_HEAT; cooler only → P_COOL; neither → P_IDLE.
- P_FAULT is absorbing. Only `load` or reset leave it. While in it, `current_temp` is frozen, the prescaler is held at 0, and `fault`=1.
- Prescaler: a mod-DIV counter with DIV = HEAT_DIV, COOL_DIV or DRIFT_DIV, selected by state.
  - It clears to 0 on every state change.
  - When the state is unchanged and the count equals DIV−1, a step event fires and the counter wraps to 0.
- Step event:
  - P_HEAT: temp+1, saturating at `TEMP_MAX`.
  - P_COOL: temp−1, saturating at `TEMP_MIN`.
  - P_IDLE: move 1 toward `AMBIENT_TEMP`; no change if already equal.
- Arithmetic is done in 9 bits, then clamped to [`TEMP_MIN`,`TEMP_MAX`].
- `temp_step` asserts only when the value actually changes. A step blocked at a clamp produces no pulse.
- `load` has the highest synchronous priority:
  - `current_temp` is set to `load_temp`, clamped.
  - The state goes to P_IDLE, the prescaler to 0 and `fault` to 0.
  - No `temp_step` pulse.
  - The inputs are re-evaluated on the next edge.

## Timing
- Command change at edge E0 → state updates at E0 → first step lands on `current_temp` at edge E0+DIV. After that, one step every DIV edges.
- `temp_step` is registered and coincides with the new `current_temp` value.
- Both commands high at edge E → `fault`=1 and temp frozen from E. Any prescaler progress at E is discarded.
- Asserting `reset` mid-operation forces all outputs to reset values immediately, without waiting for a clock edge. Release is synchronous to `clk`.

## Configuration
- `PLANT_NOISE_EN` defined:
  - Adds an 8-bit Fibonacci LFSR: taps 8,6,5,4, seed 8'hA5, loaded at reset and on `load`.
  - The LFSR advances on every step event.
  - A step event is skipped (no change, no pulse) when `lfsr[0]`=1 before the advance.
- `PLANT_NOISE_EN` undefined: no LFSR is present, and every step event applies.

## Structure
- Shared package `thermal_pkg`:
  - `plant_state_t` enum {P_IDLE, P_HEAT, P_COOL, P_FAULT}
  - `TEMP_W`=8
  - LFSR seed constant
- One sub-module, `plant_prescaler`: a mod-N counter with synchronous clear and a `tick` output, where N is a runtime input.

## Test plan
All tests use default parameters and `PLANT_NOISE_EN` undefined.
- Release reset, hold `heater_on`=1 → 40 edges after state entry, `current_temp`=35 with exactly 10 `temp_step` pulses.
- `load` 118, then heat → 119 at +4, 120 at +8, then held. `at_limit`=1, no further pulses.
- `load` 30, both commands low → temp 25 after 80 edges (one step per 16), then constant.
- Heat to 27, then both commands high → `fault`=1 and temp holds 27. Drop both: still `fault`, still 27. `load` 50 → `fault`=0, temp 50.
- `load` 3, `cooler_on`=1 → 2, 1, 0 at 4-edge spacing, then stuck at 0 with `at_limit`=1.
- Assert `reset` between clock edges mid-heating → `current_temp`=25 and `temp_step`=0 without waiting for a clock edge.
